multicycle_ctrl_p: RTL and testbench

Parametrised multicycle MIPS control unit: a Moore FSM that sequences fetch, decode, execute, memory and write-back for the datapath. It adds configurable memory wait states, a configurable mult/div busy window, precise exceptions (bad opcode, overflow, divide-by-zero) with EPC capture, and a BREAK halt state. It sits beside the datapath, reads the IR opcode/funct fields and the ALU flags, and drives every mux select and write enable.

---
 rtl/multicycle_ctrl_p_if.sv | 41 ++++
 rtl/multicycle_ctrl_p.sv | 213 +++++++++++++++++++++
 tb/tb_multicycle_ctrl_p.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_p_if.sv
// Control-unit <-> datapath bundle: IR fields and ALU flags in, mux selects and write enables out.
interface multicycle_ctrl_p_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       gt;
  logic       lt;
  logic       overflow;
  logic       div_zero;
  logic       pc_write;
  logic [1:0] pc_src;
  logic       iord;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic [1:0] reg_dst;
  logic [2:0] mem_to_reg;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_op;
  logic       md_start;
  logic       md_sel;
  logic       hilo_write;
  logic       epc_write;
  logic [1:0] exc_cause;
  logic [5:0] state;

  modport master (
    input  opcode, funct, zero, gt, lt, overflow, div_zero,
    output pc_write, pc_src, iord, mem_write, ir_write, reg_write, reg_dst,
           mem_to_reg, alu_src_a, alu_src_b, alu_op, md_start, md_sel,
           hilo_write, epc_write, exc_cause, state
  );

  modport slave (
    output opcode, funct, zero, gt, lt, overflow, div_zero,
    input  pc_write, pc_src, iord, mem_write, ir_write, reg_write, reg_dst,
           mem_to_reg, alu_src_a, alu_src_b, alu_op, md_start, md_sel,
           hilo_write, epc_write, exc_cause, state
  );
endinterface

// File: rtl/multicycle_ctrl_p.sv
// Moore multicycle MIPS control FSM with memory/mult-div wait counters, precise exceptions and HALT.
// Outputs decode from the state register; only BRANCH pc_write looks at the live ALU flags.
module multicycle_ctrl_p #(
  parameter int MEM_LAT   = 1,
  parameter int MD_CYCLES = 32
) (
  input  logic          clk,
  input  logic          reset,
  multicycle_ctrl_p_if.master bus
);
  localparam int CNT_MAX = (MEM_LAT > MD_CYCLES) ? MEM_LAT : MD_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] LAT_LOAD = CW'(MEM_LAT - 1);
  localparam logic [CW-1:0] MD_LOAD  = CW'(MD_CYCLES - 1);

  typedef enum logic [5:0] {
    S_RESET = 6'd0,  S_FETCH = 6'd1,    S_IR_LOAD = 6'd2,  S_DECODE = 6'd3,
    S_EXEC_R = 6'd4, S_EXEC_I = 6'd5,   S_ALU_WB = 6'd6,   S_ADDR = 6'd7,
    S_MEM_RD = 6'd8, S_LOAD_WB = 6'd9,  S_MEM_WR = 6'd10,  S_BRANCH = 6'd11,
    S_JUMP = 6'd12,  S_JAL = 6'd13,     S_JR = 6'd14,      S_MD_RUN = 6'd15,
    S_MD_WB = 6'd16, S_MF_WB = 6'd17,   S_LUI_WB = 6'd18,  S_EXC_OPC = 6'd19,
    S_EXC_OVF = 6'd20, S_EXC_DIV0 = 6'd21, S_EXC_JMP = 6'd22, S_HALT = 6'd23
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    cause_q, cause_d;
  logic          md_div_q, md_div_d;
  logic          rtype;

  assign rtype = (bus.opcode == 6'h00);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_RESET;
      cnt_q    <= '0;
      cause_q  <= 2'b00;
      md_div_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cause_q  <= cause_d;
      md_div_q <= md_div_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cause_d  = cause_q;
    md_div_d = md_div_q;
    case (state_q)
      S_RESET:   state_d = S_FETCH;
      S_FETCH:   if (cnt_q == '0) state_d = S_IR_LOAD;
      S_IR_LOAD: state_d = S_DECODE;
      S_DECODE: begin
        md_div_d = (bus.funct == 6'h1a);
        if (rtype) begin
          case (bus.funct)
            6'h20, 6'h22, 6'h24, 6'h2a: state_d = S_EXEC_R;
            6'h08:                      state_d = S_JR;
            6'h18:                      state_d = S_MD_RUN;
            6'h1a:                      state_d = bus.div_zero ? S_EXC_DIV0 : S_MD_RUN;
            6'h10, 6'h12:               state_d = S_MF_WB;
            6'h0d:                      state_d = S_HALT;
            default:                    state_d = S_EXC_OPC;
          endcase
        end else begin
          case (bus.opcode)
            6'h08:                      state_d = S_EXEC_I;
            6'h23, 6'h2b:               state_d = S_ADDR;
            6'h04, 6'h05, 6'h06, 6'h07: state_d = S_BRANCH;
            6'h0f:                      state_d = S_LUI_WB;
            6'h02:                      state_d = S_JUMP;
            6'h03:                      state_d = S_JAL;
            default:                    state_d = S_EXC_OPC;
          endcase
        end
      end
      S_EXEC_R: state_d = ((bus.funct == 6'h20 || bus.funct == 6'h22) && bus.overflow)
                          ? S_EXC_OVF : S_ALU_WB;
      S_EXEC_I: state_d = bus.overflow ? S_EXC_OVF : S_ALU_WB;
      S_ADDR:   state_d = (bus.opcode == 6'h23) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: if (cnt_q == '0) state_d = S_LOAD_WB;
      S_MEM_WR: if (cnt_q == '0) state_d = S_FETCH;
      S_MD_RUN: if (cnt_q == '0) state_d = S_MD_WB;
      S_EXC_OPC, S_EXC_OVF, S_EXC_DIV0: state_d = S_EXC_JMP;
      S_HALT:   state_d = S_HALT;
      S_ALU_WB, S_LOAD_WB, S_BRANCH, S_JUMP, S_JAL, S_JR,
      S_MD_WB, S_MF_WB, S_LUI_WB, S_EXC_JMP: state_d = S_FETCH;
      default:  state_d = S_RESET;
    endcase

    // Wait counter reloads on any state change and counts down while the state holds.
    if (state_d != state_q)
      cnt_d = (state_d == S_MD_RUN) ? MD_LOAD : LAT_LOAD;
    else if (cnt_q != '0)
      cnt_d = cnt_q - 1'b1;

    case (state_d)
      S_EXC_OPC:  cause_d = 2'b01;
      S_EXC_OVF:  cause_d = 2'b10;
      S_EXC_DIV0: cause_d = 2'b11;
      default:    cause_d = cause_q;
    endcase
  end

  always_comb begin
    bus.pc_write   = 1'b0;
    bus.pc_src     = 2'b00;
    bus.iord       = 1'b0;
    bus.mem_write  = 1'b0;
    bus.ir_write   = 1'b0;
    bus.reg_write  = 1'b0;
    bus.reg_dst    = 2'b00;
    bus.mem_to_reg = 3'b000;
    bus.alu_src_a  = 2'b00;
    bus.alu_src_b  = 2'b00;
    bus.alu_op     = 3'b000;
    bus.md_start   = 1'b0;
    bus.md_sel     = 1'b0;
    bus.hilo_write = 1'b0;
    bus.epc_write  = 1'b0;
    case (state_q)
      S_IR_LOAD: begin
        bus.ir_write  = 1'b1;
        bus.pc_write  = 1'b1;
        bus.alu_src_b = 2'b01;
      end
      S_DECODE:  bus.alu_src_b = 2'b11;
      S_EXEC_R: begin
        bus.alu_src_a = 2'b01;
        case (bus.funct)
          6'h22:   bus.alu_op = 3'b001;
          6'h24:   bus.alu_op = 3'b010;
          6'h2a:   bus.alu_op = 3'b011;
          default: bus.alu_op = 3'b000;
        endcase
      end
      S_EXEC_I, S_ADDR: begin
        bus.alu_src_a = 2'b01;
        bus.alu_src_b = 2'b10;
      end
      S_ALU_WB: begin
        bus.reg_write = 1'b1;
        bus.reg_dst   = rtype ? 2'b01 : 2'b00;
      end
      S_MEM_RD:  bus.iord = 1'b1;
      S_MEM_WR: begin
        bus.iord      = 1'b1;
        bus.mem_write = 1'b1;
      end
      S_LOAD_WB: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 3'b001;
      end
      S_BRANCH: begin
        bus.alu_src_a = 2'b01;
        bus.alu_op    = 3'b001;
        bus.pc_src    = 2'b01;
        case (bus.opcode)
          6'h04:   bus.pc_write = bus.zero;
          6'h05:   bus.pc_write = ~bus.zero;
          6'h06:   bus.pc_write = bus.lt | bus.zero;
          default: bus.pc_write = bus.gt;
        endcase
      end
      S_JUMP: begin
        bus.pc_src   = 2'b10;
        bus.pc_write = 1'b1;
      end
      S_JAL: begin
        bus.pc_src     = 2'b10;
        bus.pc_write   = 1'b1;
        bus.reg_write  = 1'b1;
        bus.reg_dst    = 2'b10;
        bus.mem_to_reg = 3'b100;
      end
      // rt is $0 for jr, so A + B passes the register target straight through.
      S_JR: begin
        bus.alu_src_a = 2'b01;
        bus.pc_write  = 1'b1;
      end
      S_MD_RUN: begin
        bus.md_start = (cnt_q == MD_LOAD);
        bus.md_sel   = md_div_q;
      end
      S_MD_WB:   bus.hilo_write = 1'b1;
      S_MF_WB: begin
        bus.reg_write  = 1'b1;
        bus.reg_dst    = 2'b01;
        bus.mem_to_reg = (bus.funct == 6'h10) ? 3'b010 : 3'b011;
      end
      S_LUI_WB: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 3'b101;
      end
      S_EXC_OPC, S_EXC_OVF, S_EXC_DIV0: begin
        bus.epc_write = 1'b1;
        bus.alu_src_b = 2'b01;
        bus.alu_op    = 3'b001;
      end
      S_EXC_JMP: begin
        bus.pc_src   = 2'b11;
        bus.pc_write = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.exc_cause = cause_q;
  assign bus.state     = state_q;
endmodule

// File: tb/tb_multicycle_ctrl_p.sv
// Directed bench: per-cycle expected output vectors queued per instruction and compared each cycle.
module tb_multicycle_ctrl_p;
  localparam int L  = 3;
  localparam int MD = 4;
  localparam logic [5:0] S_RESET = 6'd0, S_FETCH = 6'd1, S_IR_LOAD = 6'd2, S_DECODE = 6'd3,
    S_EXEC_R = 6'd4, S_EXEC_I = 6'd5, S_ALU_WB = 6'd6, S_ADDR = 6'd7, S_MEM_RD = 6'd8,
    S_LOAD_WB = 6'd9, S_MEM_WR = 6'd10, S_BRANCH = 6'd11, S_JUMP = 6'd12, S_JAL = 6'd13,
    S_JR = 6'd14, S_MD_RUN = 6'd15, S_MD_WB = 6'd16, S_MF_WB = 6'd17, S_LUI_WB = 6'd18,
    S_EXC_OPC = 6'd19, S_EXC_OVF = 6'd20, S_EXC_DIV0 = 6'd21, S_EXC_JMP = 6'd22, S_HALT = 6'd23;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  multicycle_ctrl_p_if bus();
  multicycle_ctrl_p #(.MEM_LAT(L), .MD_CYCLES(MD)) dut (.clk(clk), .reset(reset), .bus(bus));

  int          errors = 0;
  int          checks = 0;
  int          idx;
  string       tag;
  logic [30:0] sb[$];
  logic        br_e;
  logic        mdsel_e;
  logic [2:0]  rop_e;
  logic [2:0]  mf_e;
  logic [1:0]  rdst_e;
  logic [1:0]  cause_e;

  function automatic logic [30:0] mdl(input logic [5:0] st, input logic first);
    logic pcw, iord, mw, irw, rw, mds, mdsl, hw, ew;
    logic [1:0] psrc, rd, a, b;
    logic [2:0] m2r, op;
    {pcw, iord, mw, irw, rw, mds, mdsl, hw, ew} = '0;
    {psrc, rd, a, b, m2r, op} = '0;
    case (st)
      S_IR_LOAD: begin irw = 1; pcw = 1; b = 2'b01; end
      S_DECODE:  b = 2'b11;
      S_EXEC_R:  begin a = 2'b01; op = rop_e; end
      S_EXEC_I, S_ADDR: begin a = 2'b01; b = 2'b10; end
      S_ALU_WB:  begin rw = 1; rd = rdst_e; end
      S_MEM_RD:  iord = 1;
      S_MEM_WR:  begin iord = 1; mw = 1; end
      S_LOAD_WB: begin rw = 1; m2r = 3'b001; end
      S_BRANCH:  begin a = 2'b01; op = 3'b001; psrc = 2'b01; pcw = br_e; end
      S_JUMP:    begin psrc = 2'b10; pcw = 1; end
      S_JAL:     begin psrc = 2'b10; pcw = 1; rw = 1; rd = 2'b10; m2r = 3'b100; end
      S_JR:      begin a = 2'b01; pcw = 1; end
      S_MD_RUN:  begin mds = first; mdsl = mdsel_e; end
      S_MD_WB:   hw = 1;
      S_MF_WB:   begin rw = 1; rd = 2'b01; m2r = mf_e; end
      S_LUI_WB:  begin rw = 1; m2r = 3'b101; end
      S_EXC_OPC, S_EXC_OVF, S_EXC_DIV0: begin ew = 1; b = 2'b01; op = 3'b001; end
      S_EXC_JMP: begin psrc = 2'b11; pcw = 1; end
      default: ;
    endcase
    return {st, pcw, psrc, iord, mw, irw, rw, rd, m2r, a, b, op, mds, mdsl, hw, ew, cause_e};
  endfunction

  function automatic logic [30:0] obs();
    return {bus.state, bus.pc_write, bus.pc_src, bus.iord, bus.mem_write, bus.ir_write,
            bus.reg_write, bus.reg_dst, bus.mem_to_reg, bus.alu_src_a, bus.alu_src_b,
            bus.alu_op, bus.md_start, bus.md_sel, bus.hilo_write, bus.epc_write, bus.exc_cause};
  endfunction

  task automatic exp_n(input logic [5:0] st, input int n);
    for (int i = 0; i < n; i++) sb.push_back(mdl(st, i == 0));
  endtask

  task automatic front();
    exp_n(S_FETCH, L);
    exp_n(S_IR_LOAD, 1);
    exp_n(S_DECODE, 1);
  endtask

  task automatic check(input logic [30:0] e);
    logic [30:0] o;
    o = obs();
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s[%0d] observed=%h expected=%h", tag, idx, o, e);
    end
    idx++;
  endtask

  task automatic drain();
    while (sb.size() > 0) begin
      check(sb.pop_front());
      @(negedge clk);
    end
  endtask

  task automatic start(input string t, input logic [5:0] op, input logic [5:0] fn,
                       input logic z, input logic g, input logic l, input logic ov,
                       input logic dz);
    tag = t;
    idx = 0;
    bus.opcode = op;  bus.funct = fn;  bus.zero = z;  bus.gt = g;
    bus.lt = l;       bus.overflow = ov;  bus.div_zero = dz;
  endtask

  initial begin
    br_e = 0; mdsel_e = 0; rop_e = 0; mf_e = 0; rdst_e = 0; cause_e = 0;
    reset = 1'b1;
    start("reset", 6'h23, 6'h20, 1, 1, 1, 1, 1);
    @(negedge clk);
    exp_n(S_RESET, 2); drain();
    reset = 1'b0;

    start("add", 6'h00, 6'h20, 0, 0, 0, 0, 0); rop_e = 3'b000; rdst_e = 2'b01;
    exp_n(S_RESET, 1); front(); exp_n(S_EXEC_R, 1); exp_n(S_ALU_WB, 1); drain();

    start("sub_ovf", 6'h00, 6'h22, 0, 0, 0, 1, 0); rop_e = 3'b001;
    front(); exp_n(S_EXEC_R, 1); cause_e = 2'b10; exp_n(S_EXC_OVF, 1); exp_n(S_EXC_JMP, 1); drain();

    start("and_ovf_ignored", 6'h00, 6'h24, 0, 0, 0, 1, 0); rop_e = 3'b010;
    front(); exp_n(S_EXEC_R, 1); exp_n(S_ALU_WB, 1); drain();

    start("slt", 6'h00, 6'h2a, 0, 0, 1, 0, 0); rop_e = 3'b011;
    front(); exp_n(S_EXEC_R, 1); exp_n(S_ALU_WB, 1); drain();

    start("addi", 6'h08, 6'h00, 0, 0, 0, 0, 0); rdst_e = 2'b00;
    front(); exp_n(S_EXEC_I, 1); exp_n(S_ALU_WB, 1); drain();

    start("lw", 6'h23, 6'h00, 0, 0, 0, 0, 0);
    front(); exp_n(S_ADDR, 1); exp_n(S_MEM_RD, L); exp_n(S_LOAD_WB, 1); drain();

    start("sw", 6'h2b, 6'h00, 0, 0, 0, 0, 0);
    front(); exp_n(S_ADDR, 1); exp_n(S_MEM_WR, L); drain();

    start("beq_taken", 6'h04, 6'h00, 1, 0, 0, 0, 0); br_e = 1;
    front(); exp_n(S_BRANCH, 1); drain();
    start("beq_not", 6'h04, 6'h00, 0, 1, 0, 0, 0); br_e = 0;
    front(); exp_n(S_BRANCH, 1); drain();
    start("bne_taken", 6'h05, 6'h00, 0, 0, 1, 0, 0); br_e = 1;
    front(); exp_n(S_BRANCH, 1); drain();
    start("ble_not", 6'h06, 6'h00, 0, 1, 0, 0, 0); br_e = 0;
    front(); exp_n(S_BRANCH, 1); drain();
    start("ble_eq", 6'h06, 6'h00, 1, 0, 0, 0, 0); br_e = 1;
    front(); exp_n(S_BRANCH, 1); drain();
    start("bgt_taken", 6'h07, 6'h00, 0, 1, 0, 0, 0); br_e = 1;
    front(); exp_n(S_BRANCH, 1); drain();

    start("j", 6'h02, 6'h00, 0, 0, 0, 0, 0);
    front(); exp_n(S_JUMP, 1); drain();
    start("jal", 6'h03, 6'h00, 0, 0, 0, 0, 0);
    front(); exp_n(S_JAL, 1); drain();
    start("jr", 6'h00, 6'h08, 0, 0, 0, 0, 0);
    front(); exp_n(S_JR, 1); drain();

    start("mult", 6'h00, 6'h18, 0, 0, 0, 0, 1); mdsel_e = 0;
    front(); exp_n(S_MD_RUN, MD); exp_n(S_MD_WB, 1); drain();
    start("div", 6'h00, 6'h1a, 0, 0, 0, 0, 0); mdsel_e = 1;
    front(); exp_n(S_MD_RUN, MD); exp_n(S_MD_WB, 1); drain();
    start("div0", 6'h00, 6'h1a, 0, 0, 0, 0, 1);
    front(); cause_e = 2'b11; exp_n(S_EXC_DIV0, 1); exp_n(S_EXC_JMP, 1); drain();

    start("bad_opcode", 6'h3f, 6'h20, 0, 0, 0, 0, 0);
    front(); cause_e = 2'b01; exp_n(S_EXC_OPC, 1); exp_n(S_EXC_JMP, 1); drain();
    start("addi_ovf", 6'h08, 6'h00, 0, 0, 0, 1, 0);
    front(); exp_n(S_EXEC_I, 1); cause_e = 2'b10; exp_n(S_EXC_OVF, 1); exp_n(S_EXC_JMP, 1); drain();
    start("bad_funct", 6'h00, 6'h3e, 0, 0, 0, 0, 0);
    front(); cause_e = 2'b01; exp_n(S_EXC_OPC, 1); exp_n(S_EXC_JMP, 1); drain();

    start("mfhi", 6'h00, 6'h10, 0, 0, 0, 0, 0); mf_e = 3'b010;
    front(); exp_n(S_MF_WB, 1); drain();
    start("mflo", 6'h00, 6'h12, 0, 0, 0, 0, 0); mf_e = 3'b011;
    front(); exp_n(S_MF_WB, 1); drain();
    start("lui", 6'h0f, 6'h00, 0, 0, 0, 0, 0);
    front(); exp_n(S_LUI_WB, 1); drain();

    start("halt", 6'h00, 6'h0d, 1, 1, 1, 1, 1);
    front(); exp_n(S_HALT, 100); drain();

    reset = 1'b1; #1;
    tag = "reset_from_halt"; idx = 0; cause_e = 2'b00;
    check(mdl(S_RESET, 0));
    @(negedge clk); reset = 1'b0;

    start("sw_abort", 6'h2b, 6'h00, 0, 0, 0, 0, 0);
    exp_n(S_RESET, 1); front(); exp_n(S_ADDR, 1); exp_n(S_MEM_WR, 1); drain();
    check(mdl(S_MEM_WR, 0));
    reset = 1'b1; #1;
    check(mdl(S_RESET, 0));
    @(negedge clk); reset = 1'b0;

    start("j_after_abort", 6'h02, 6'h00, 0, 0, 0, 0, 0);
    exp_n(S_RESET, 1); front(); exp_n(S_JUMP, 1); drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
